// File: rtl/fft_pkg.sv
// fft_pkg
// Shared definitions for the FFT datapath blocks.
//   calc_two_pi_q : 2*pi scaled by 2^bits, rounded to nearest integer
//   TWO_PI_Q      : 2*pi in Q(FRAC_BITS+GUARD_BITS) for the default angle format
//   angle_t       : signed angle word in the default Q16.16 radian format
//   state_t       : control states of the twiddle angle generator
package fft_pkg;

    localparam int FRAC_BITS  = 16;
    localparam int GUARD_BITS = 16;
    localparam int ANGLE_W    = 32;

    // Elaboration-time only. Doubling in a loop keeps the scaling exact in
    // real arithmetic. The final integer conversion rounds to nearest.
    function automatic logic [63:0] calc_two_pi_q(input int bits);
        real v;
        v = 6.283185307179586476925;
        for (int i = 0; i < bits; i++) begin
            v = v * 2.0;
        end
        return 64'(longint'(v));
    endfunction

    localparam logic [63:0] TWO_PI_Q = calc_two_pi_q(FRAC_BITS + GUARD_BITS);

    typedef logic signed [ANGLE_W-1:0] angle_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_ERR
    } state_t;

endpackage

// File: rtl/twiddle_angle_gen.sv
// twiddle_angle_gen
// Streams the twiddle angles for one radix-2 FFT stage, one per handshake.
// For stage s, the angles are ordered by group first and then by k inside
// the group. Each angle is -k*2*pi/2^s, or the positive value for an inverse
// transform. The angle is built with an accumulator, so the block needs no
// multiplier and no table.
// Ports:
//   i_clk      clock; all state changes on the rising edge
//   i_rst      synchronous active-high reset
//   i_start    frame request; honoured when idle or on the last-beat handshake
//   i_stage    FFT stage, legal range 1..LOG2N
//   i_inverse  1 gives positive (IFFT) angles
//   i_ready    consumer accepts the current beat
//   o_busy     a frame is in progress
//   o_valid    o_angle / o_k / o_last are valid
//   o_angle    signed Q(W-FRAC).FRAC angle in radians
//   o_k        butterfly index inside its group
//   o_last     final beat of the frame
//   o_err      one-cycle pulse after an illegal stage request
module twiddle_angle_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 6,
    parameter int W     = 32,
    parameter int FRAC  = 16,
    parameter int GUARD = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [$clog2(LOG2N+1)-1:0]        i_stage,
    input  logic                              i_inverse,
    input  logic                              i_ready,
    output logic                              o_busy,
    output logic                              o_valid,
    output logic [W-1:0]                      o_angle,
    output logic [((LOG2N > 1) ? LOG2N-1 : 1)-1:0] o_k,
    output logic                              o_last,
    output logic                              o_err
);

    localparam int KW = (LOG2N > 1) ? LOG2N - 1 : 1;
    localparam int AW = W + GUARD;

    localparam logic [63:0]   TWO_PI_RAW = calc_two_pi_q(FRAC + GUARD);
    localparam logic [AW-1:0] TWO_PI_ACC = AW'(TWO_PI_RAW);
    localparam logic [AW-1:0] ROUND_HALF = AW'(1) << (GUARD - 1);

    state_t        state;
    logic [AW-1:0] acc;
    logic [AW-1:0] step;
    logic [KW-1:0] g_cnt;
    logic [KW-1:0] half_m;
    logic [KW-1:0] groups_m;
    logic          inv_q;

    logic          stage_legal;
    int            shift_amt;
    logic [KW-1:0] new_half_m;
    logic [KW-1:0] new_groups_m;
    logic [AW-1:0] new_step;
    logic          handshake;
    logic          last_hs;
    logic          start_ok;
    logic          k_wrap;
    logic [KW-1:0] k_nxt;
    logic [KW-1:0] g_nxt;
    logic [AW-1:0] acc_nxt;
    logic          last_nxt;
    logic [W-1:0]  mag_nxt;
    logic [W-1:0]  angle_nxt;

    // Next-state values. Stage decoding covers the frame that would start
    // this cycle. Counter and accumulator stepping covers the beat after the
    // current one. A stage that is out of range is forced to shift by 1 so
    // that the shifters never see a negative amount. Those values are not
    // used in that case.
    always_comb begin
        stage_legal  = (i_stage != '0) && (int'(i_stage) <= LOG2N);
        shift_amt    = stage_legal ? int'(i_stage) : 1;
        new_half_m   = KW'((1 << (shift_amt - 1)) - 1);
        new_groups_m = KW'(((1 << LOG2N) >> shift_amt) - 1);
        new_step     = TWO_PI_ACC >> shift_amt;

        handshake    = o_valid & i_ready;
        last_hs      = handshake & o_last;
        start_ok     = i_start & ((state != ST_RUN) | last_hs);

        k_wrap       = (o_k == half_m);
        k_nxt        = k_wrap ? '0 : o_k + 1'b1;
        g_nxt        = k_wrap ? g_cnt + 1'b1 : g_cnt;
        acc_nxt      = k_wrap ? '0 : acc + step;
        last_nxt     = (g_nxt == groups_m) && (k_nxt == half_m);

        mag_nxt      = W'((acc_nxt + ROUND_HALF) >> GUARD);
        angle_nxt    = inv_q ? mag_nxt : ('0 - mag_nxt);
    end

    // Control FSM and registered outputs. A start takes priority over the
    // handshake that ends the current frame. Because of that, a start on the
    // last beat begins the new frame with no gap. An illegal stage goes
    // through ST_ERR for one cycle so that o_err is a single pulse. The
    // outputs hold their values whenever no handshake happens.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
            o_err    <= 1'b0;
            o_angle  <= '0;
            o_k      <= '0;
            g_cnt    <= '0;
            acc      <= '0;
            step     <= '0;
            half_m   <= '0;
            groups_m <= '0;
            inv_q    <= 1'b0;
        end else begin
            o_err <= 1'b0;
            if (start_ok) begin
                if (stage_legal) begin
                    state    <= ST_RUN;
                    o_busy   <= 1'b1;
                    o_valid  <= 1'b1;
                    o_last   <= (new_half_m == '0) && (new_groups_m == '0);
                    o_angle  <= '0;
                    o_k      <= '0;
                    g_cnt    <= '0;
                    acc      <= '0;
                    step     <= new_step;
                    half_m   <= new_half_m;
                    groups_m <= new_groups_m;
                    inv_q    <= i_inverse;
                end else begin
                    state   <= ST_ERR;
                    o_err   <= 1'b1;
                    o_busy  <= 1'b0;
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (last_hs) begin
                            state   <= ST_IDLE;
                            o_busy  <= 1'b0;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                        end else if (handshake) begin
                            o_k     <= k_nxt;
                            g_cnt   <= g_nxt;
                            acc     <= acc_nxt;
                            o_angle <= angle_nxt;
                            o_last  <= last_nxt;
                        end
                    end
                    ST_ERR: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_twiddle_angle_gen.sv
// tb_twiddle_angle_gen
// Bench for twiddle_angle_gen. It uses two instances:
//   dut  : LOG2N=6. It is checked every cycle against a beat-queue model.
//   dut3 : LOG2N=3. It is checked with a short run against literal angles.
// The model builds each frame with the closed-form formula
// (k*STEP + 2^15) >> 16, and predicts start acceptance, handshakes, o_err
// and reset from the interface rules.
module tb_twiddle_angle_gen;
    import fft_pkg::*;

    localparam int LOG2N = 6;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [2:0]  i_stage = '0;
    logic        i_inverse = 1'b0;
    logic        i_ready = 1'b1;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_angle;
    logic [4:0]  o_k;
    logic        o_last;
    logic        o_err;

    logic        s3_start = 1'b0;
    logic [1:0]  s3_stage = '0;
    logic        s3_inverse = 1'b0;
    logic        s3_ready = 1'b1;
    logic        d3_busy;
    logic        d3_valid;
    logic [31:0] d3_angle;
    logic [1:0]  d3_k;
    logic        d3_last;
    logic        d3_err;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    typedef struct {
        angle_t angle;
        int     k;
        bit     last;
    } beat_t;

    beat_t q[$];
    bit    exp_err = 1'b0;
    bit    zero_exp = 1'b1;

    twiddle_angle_gen #(.LOG2N(LOG2N), .W(32), .FRAC(16), .GUARD(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stage(i_stage),
        .i_inverse(i_inverse), .i_ready(i_ready), .o_busy(o_busy),
        .o_valid(o_valid), .o_angle(o_angle), .o_k(o_k), .o_last(o_last),
        .o_err(o_err)
    );

    twiddle_angle_gen #(.LOG2N(3), .W(32), .FRAC(16), .GUARD(16)) dut3 (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(s3_start), .i_stage(s3_stage),
        .i_inverse(s3_inverse), .i_ready(s3_ready), .o_busy(d3_busy),
        .o_valid(d3_valid), .o_angle(d3_angle), .o_k(d3_k), .o_last(d3_last),
        .o_err(d3_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // The reference angle comes straight from the formula:
    // STEP = round(2*pi*2^32) >> s, and the magnitude is (k*STEP + 2^15) >> 16.
    function automatic angle_t model_angle(input int k, input int s, input bit inv);
        real    r;
        longint tp;
        longint stp;
        longint m;
        r   = 2.0 * 3.14159265358979323846 * 4294967296.0;
        tp  = longint'(r);
        stp = tp >>> s;
        m   = (longint'(k) * stp + 64'sd32768) >>> 16;
        return inv ? angle_t'(32'(m)) : angle_t'(32'(-m));
    endfunction

    task automatic push_frame(input int s, input bit inv);
        beat_t b;
        int half;
        int groups;
        half   = 1 << (s - 1);
        groups = (1 << LOG2N) >> s;
        for (int g = 0; g < groups; g++) begin
            for (int k = 0; k < half; k++) begin
                b.angle = model_angle(k, s, inv);
                b.k     = k;
                b.last  = (g == groups - 1) && (k == half - 1);
                q.push_back(b);
            end
        end
    endtask

    // Per-cycle compare against the model. After the compare, the model is
    // moved forward using the inputs the DUT will sample at the next edge.
    initial begin
        bit have;
        bit hs;
        bit lhs;
        bit acc;
        bit legal;
        forever begin
            @(negedge i_clk);
            have = (q.size() != 0);
            check_output("valid", o_valid, have);
            check_output("busy", o_busy, have);
            check_output("err", o_err, exp_err);
            if (have) begin
                check_output("angle", o_angle, $unsigned(q[0].angle));
                check_output("k", o_k, q[0].k);
                check_output("last", o_last, q[0].last);
            end else begin
                check_output("last_idle", o_last, 0);
                if (zero_exp) begin
                    check_output("angle_zero", o_angle, 0);
                    check_output("k_zero", o_k, 0);
                end
            end
            if (i_rst) begin
                q.delete();
                exp_err  = 1'b0;
                zero_exp = 1'b1;
            end else begin
                hs    = have && i_ready;
                lhs   = hs && q[0].last;
                acc   = i_start && (!have || lhs);
                legal = (i_stage != 0) && (int'(i_stage) <= LOG2N);
                if (hs) begin
                    void'(q.pop_front());
                    hs_count++;
                end
                exp_err = acc && !legal;
                if (acc && legal) begin
                    push_frame(int'(i_stage), i_inverse);
                    zero_exp = 1'b0;
                end
            end
        end
    end

    task automatic apply_stimulus(input bit start, input int stage, input bit inv, input bit ready, input bit rst);
        @(posedge i_clk);
        #1;
        i_start   = start;
        i_stage   = 3'(stage);
        i_inverse = inv;
        i_ready   = ready;
        i_rst     = rst;
    endtask

    task automatic run_frame(input int stage, input bit inv, input bit stall);
        apply_stimulus(1'b1, stage, inv, 1'b1, 1'b0);
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(1'b0, stage, inv, stall ? ($urandom_range(0, 2) != 0) : 1'b1, 1'b0);
            if (!o_busy) break;
        end
        check_output("frame_done", o_busy, 0);
    endtask

    initial begin
        logic [31:0] exp3 [4];
        int n3;
        int h0;
        exp3[0] = 32'h00000000;
        exp3[1] = 32'hFFFF36F0;
        exp3[2] = 32'hFFFE6DE0;
        exp3[3] = 32'hFFFDA4D0;

        // Hand-computed values that pin the reference model itself.
        check_output("pin_s3k1", $unsigned(model_angle(1, 3, 1'b0)), 32'hFFFF36F0);
        check_output("pin_s3k3", $unsigned(model_angle(3, 3, 1'b0)), 32'hFFFDA4D0);
        check_output("pin_s2k1i", $unsigned(model_angle(1, 2, 1'b1)), 32'h00019220);
        check_output("pin_s1k0", $unsigned(model_angle(0, 1, 1'b0)), 32'h00000000);

        apply_stimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);

        // Eight-point stage 3 on the small instance, forward, always ready.
        @(posedge i_clk);
        #1;
        i_rst    = 1'b0;
        s3_start = 1'b1;
        s3_stage = 2'd3;
        @(posedge i_clk);
        #1;
        s3_start = 1'b0;
        n3 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (d3_valid && s3_ready) begin
                if (n3 < 4) begin
                    check_output("d3_angle", d3_angle, exp3[n3]);
                    check_output("d3_last", d3_last, n3 == 3);
                end
                n3++;
            end
        end
        check_output("d3_beats", n3, 4);
        check_output("d3_busy_end", d3_busy, 0);
        check_output("d3_err", d3_err, 0);

        // Stage 2 inverse. Stage 6 forward with random stalls, then stage 1.
        run_frame(2, 1'b1, 1'b0);
        h0 = hs_count;
        run_frame(6, 1'b0, 1'b1);
        check_output("s6_beats", hs_count - h0, 32);
        run_frame(1, 1'b0, 1'b1);

        // New start on the last-beat handshake must follow with no gap.
        apply_stimulus(1'b1, 3, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 40; n++) begin
            @(posedge i_clk);
            #1;
            if (o_valid && o_last) begin
                i_start = 1'b1;
                i_stage = 3'd4;
                break;
            end
            i_start = 1'b0;
        end
        apply_stimulus(1'b0, 4, 1'b0, 1'b1, 1'b0);
        check_output("b2b_valid", o_valid, 1);
        check_output("b2b_k0", o_k, 0);
        check_output("b2b_angle0", o_angle, 0);
        for (int n = 0; n < 40; n++) begin
            apply_stimulus(1'b0, 4, 1'b0, 1'b1, 1'b0);
            if (!o_busy) break;
        end

        // Stages 0 and 7 are illegal: o_err pulses once and busy stays low.
        apply_stimulus(1'b1, 0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check_output("err_s0", o_err, 1);
        check_output("err_s0_busy", o_busy, 0);
        apply_stimulus(1'b1, 7, 1'b0, 1'b1, 1'b0);
        check_output("err_s0_pulse", o_err, 0);
        apply_stimulus(1'b0, 7, 1'b0, 1'b1, 1'b0);
        check_output("err_s7", o_err, 1);
        check_output("err_s7_busy", o_busy, 0);

        // Reset in mid-frame, with a start in the same cycle, then a fresh frame.
        apply_stimulus(1'b1, 5, 1'b0, 1'b1, 1'b0);
        repeat (5) apply_stimulus(1'b0, 5, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 5, 1'b0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 5, 1'b0, 1'b1, 1'b0);
        check_output("rst_valid", o_valid, 0);
        check_output("rst_angle", o_angle, 0);
        check_output("rst_k", o_k, 0);
        run_frame(5, 1'b0, 1'b1);

        // Random traffic: starts with any stage, stalls, occasional resets.
        for (int n = 0; n < 3000; n++) begin
            apply_stimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                           $urandom_range(0, 299) == 0);
        end
        for (int n = 0; n < 100; n++) begin
            apply_stimulus(1'b0, 1, 1'b0, 1'b1, 1'b0);
            if (!o_busy) break;
        end
        check_output("final_idle", o_busy, 0);
        @(negedge i_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
